// File: rtl/stage_accumulator.sv
// Cascade stage accumulator: sums per-feature haar values for one
// stage, then compares the saturated sum against the stage threshold.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   i_start               begin a stage (taken only while idle)
//   i_abort               drop the current stage, no result produced
//   i_num_features        feature count of the stage, latched on start
//   i_stage_threshold     unsigned pass threshold, latched on start
//   i_haarvalue_valid     i_haarvalue carries one feature result
//   i_haarvalue           unsigned feature result
//   o_ready               idle, a start will be taken
//   o_done                one-cycle pulse, o_pass/o_sum are valid
//   o_pass                stage verdict, held until the next start
//   o_sum                 saturated stage sum
//   o_feature_count       values accepted in the current stage
module stage_accumulator #(
   parameter int DATA_WIDTH = 8,
   parameter int SUM_WIDTH  = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [CNT_WIDTH-1:0]  i_num_features,
   input  logic [SUM_WIDTH-1:0]  i_stage_threshold,
   input  logic                  i_haarvalue_valid,
   input  logic [DATA_WIDTH-1:0] i_haarvalue,
   output logic                  o_ready,
   output logic                  o_done,
   output logic                  o_pass,
   output logic [SUM_WIDTH-1:0]  o_sum,
   output logic [CNT_WIDTH-1:0]  o_feature_count
);

   localparam int SW1 = SUM_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      COMPARE,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [SUM_WIDTH-1:0] sum_q, sum_d;
   logic [SUM_WIDTH-1:0] thr_q, thr_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] num_q, num_d;
   logic                 pass_q, pass_d;
   logic                 done_q, done_d;

   // One extra bit catches the carry used for saturation.
   logic [SUM_WIDTH:0]   add_w;
   logic [CNT_WIDTH-1:0] cnt_inc;

   assign add_w   = {1'b0, sum_q} + SW1'(i_haarvalue);
   assign cnt_inc = cnt_q + CNT_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      thr_d   = thr_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      pass_d  = pass_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               num_d   = i_num_features;
               thr_d   = i_stage_threshold;
               sum_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
               state_d = (i_num_features == '0) ? COMPARE : ACCUM;
            end
         end
         ACCUM: begin
            if (i_haarvalue_valid) begin
               sum_d = add_w[SUM_WIDTH] ? '1 : add_w[SUM_WIDTH-1:0];
               cnt_d = cnt_inc;
               if (cnt_inc == num_q) begin
                  state_d = COMPARE;
               end
            end
         end
         COMPARE: begin
            pass_d  = (sum_q >= thr_q);
            state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase

      // Abort overrides everything decided above, including a start.
      if (i_abort) begin
         state_d = IDLE;
         sum_d   = '0;
         cnt_d   = '0;
         num_d   = num_q;
         thr_d   = thr_q;
         pass_d  = pass_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sum_q   <= '0;
         thr_q   <= '0;
         cnt_q   <= '0;
         num_q   <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         thr_q   <= thr_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign o_ready         = (state_q == IDLE);
   assign o_done          = done_q;
   assign o_pass          = pass_q;
   assign o_sum           = sum_q;
   assign o_feature_count = cnt_q;

endmodule

// File: tb/tb_stage_accumulator.sv
// Testbench for stage_accumulator: two instances (16-bit and 8-bit sum)
// share stimulus; results are checked against queued expectations.
module tb_stage_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_start;
   logic        i_abort;
   logic [7:0]  i_num;
   logic [15:0] i_thr;
   logic [7:0]  thr8;
   logic        i_hv_valid;
   logic [7:0]  i_hv;

   logic        rdy16, done16, pass16;
   logic [15:0] sum16;
   logic [7:0]  cnt16;
   logic        rdy8, done8, pass8;
   logic [7:0]  sum8;
   logic [7:0]  cnt8;

   typedef struct {
      int sum;
      int pass;
      int cnt;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];
   int   vals[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   assign thr8 = i_thr[7:0];

   stage_accumulator u_w16 (
      .clk               (clk),
      .reset             (reset),
      .i_start           (i_start),
      .i_abort           (i_abort),
      .i_num_features    (i_num),
      .i_stage_threshold (i_thr),
      .i_haarvalue_valid (i_hv_valid),
      .i_haarvalue       (i_hv),
      .o_ready           (rdy16),
      .o_done            (done16),
      .o_pass            (pass16),
      .o_sum             (sum16),
      .o_feature_count   (cnt16)
   );

   stage_accumulator #(
      .DATA_WIDTH (8),
      .SUM_WIDTH  (8),
      .CNT_WIDTH  (8)
   ) u_w8 (
      .clk               (clk),
      .reset             (reset),
      .i_start           (i_start),
      .i_abort           (i_abort),
      .i_num_features    (i_num),
      .i_stage_threshold (thr8),
      .i_haarvalue_valid (i_hv_valid),
      .i_haarvalue       (i_hv),
      .o_ready           (rdy8),
      .o_done            (done8),
      .o_pass            (pass8),
      .o_sum             (sum8),
      .o_feature_count   (cnt8)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Monitors: every o_done must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done16 === 1'b1) begin
         if (q16.size() == 0) begin
            chk("unexpected o_done w16", 1, 0);
         end else begin
            e = q16.pop_front();
            chk("result sum w16", int'(sum16), e.sum);
            chk("result pass w16", int'(pass16), e.pass);
            chk("result count w16", int'(cnt16), e.cnt);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            chk("unexpected o_done w8", 1, 0);
         end else begin
            e = q8.pop_front();
            chk("result sum w8", int'(sum8), e.sum);
            chk("result pass w8", int'(pass8), e.pass);
            chk("result count w8", int'(cnt8), e.cnt);
         end
      end
   end

   // Runs one stage over vals; abort_at >= 0 aborts in place of that beat.
   // Called and returns at a falling edge with the DUTs idle.
   task automatic run_stage(input int thr, input int gap_max,
                            input int abort_at);
      int   n;
      int   total;
      int   g;
      int   s8;
      exp_t e;
      n     = vals.size();
      total = 0;
      chk("ready before start", int'(rdy16), 1);
      i_start = 1'b1;
      i_num   = 8'(n);
      i_thr   = 16'(thr);
      @(negedge clk);
      i_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         repeat (g) @(negedge clk);
         if (i == abort_at) begin
            i_abort    = 1'b1;
            i_hv_valid = 1'b1;
            i_hv       = 8'(vals[i]);
            @(negedge clk);
            i_abort    = 1'b0;
            i_hv_valid = 1'b0;
            chk("abort ready w16", int'(rdy16), 1);
            chk("abort ready w8", int'(rdy8), 1);
            chk("abort sum", int'(sum16), 0);
            chk("abort count", int'(cnt16), 0);
            return;
         end
         i_hv_valid = 1'b1;
         i_hv       = 8'(vals[i]);
         @(negedge clk);
         i_hv_valid = 1'b0;
         total += vals[i];
         s8 = (total > 255) ? 255 : total;
         chk("beat count", int'(cnt16), i + 1);
         chk("beat sum w16", int'(sum16), total);
         chk("beat sum w8", int'(sum8), s8);
      end
      s8     = (total > 255) ? 255 : total;
      e.sum  = total;
      e.pass = (total >= thr) ? 1 : 0;
      e.cnt  = n;
      q16.push_back(e);
      e.sum  = s8;
      e.pass = (s8 >= (thr % 256)) ? 1 : 0;
      q8.push_back(e);
      chk("done edge+0", int'(done16), 0);
      @(negedge clk);
      chk("done edge+1", int'(done16), 0);
      @(negedge clk);
      chk("done edge+2 w16", int'(done16), 1);
      chk("done edge+2 w8", int'(done8), 1);
      chk("ready with done", int'(rdy16), 1);
   endtask

   initial begin
      int n;
      int thr;
      int ab;
      reset      = 1'b1;
      i_start    = 1'b0;
      i_abort    = 1'b0;
      i_num      = '0;
      i_thr      = '0;
      i_hv_valid = 1'b0;
      i_hv       = '0;
      repeat (2) @(negedge clk);
      chk("reset ready", int'(rdy16), 1);
      chk("reset done", int'(done16), 0);
      chk("reset pass", int'(pass16), 0);
      chk("reset sum", int'(sum16), 0);
      chk("reset count", int'(cnt16), 0);
      reset = 1'b0;
      @(negedge clk);

      vals = '{100, 120, 90};
      run_stage(300, 0, -1);
      vals = '{100, 100, 100, 100};
      run_stage(500, 3, -1);
      vals.delete();
      run_stage(0, 0, -1);
      run_stage(1, 0, -1);
      vals = '{200, 200, 200};
      run_stage(500, 0, -1);
      vals = '{10, 11, 12, 13, 14};
      run_stage(20, 0, 2);
      vals = '{7};
      run_stage(5, 0, -1);

      // Simultaneous abort and start in idle: abort wins.
      i_abort = 1'b1;
      i_start = 1'b1;
      i_num   = 8'd3;
      @(negedge clk);
      i_abort = 1'b0;
      i_start = 1'b0;
      chk("abort beats start", int'(rdy16), 1);

      // Stray start during ACCUM, then reset mid-stage.
      i_start = 1'b1;
      i_num   = 8'd5;
      i_thr   = 16'd10;
      @(negedge clk);
      i_start    = 1'b0;
      i_hv_valid = 1'b1;
      i_hv       = 8'd3;
      @(negedge clk);
      i_start    = 1'b1;
      i_num      = 8'd1;
      i_hv       = 8'd4;
      @(negedge clk);
      i_start    = 1'b0;
      i_hv_valid = 1'b0;
      chk("stray start count", int'(cnt16), 2);
      chk("stray start busy", int'(rdy16), 0);
      reset      = 1'b1;
      i_start    = 1'b1;
      i_abort    = 1'b1;
      i_hv_valid = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      i_start    = 1'b0;
      i_abort    = 1'b0;
      i_hv_valid = 1'b0;
      chk("mid reset ready", int'(rdy16), 1);
      chk("mid reset sum", int'(sum16), 0);
      chk("mid reset count", int'(cnt16), 0);
      chk("mid reset pass", int'(pass16), 0);
      chk("mid reset done", int'(done16), 0);
      repeat (4) @(negedge clk);
      chk("idle after reset", int'(rdy16), 1);

      for (int s = 0; s < 40; s++) begin
         n = int'($urandom_range(6, 0));
         vals.delete();
         for (int k = 0; k < n; k++) vals.push_back(int'($urandom_range(255, 0)));
         thr = int'($urandom_range(1200, 0));
         ab  = -1;
         if (n > 0 && $urandom_range(5, 0) == 0) ab = int'($urandom_range(n - 1, 0));
         run_stage(thr, 2, ab);
      end

      repeat (4) @(negedge clk);
      chk("queues drained", q16.size() + q8.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stage_accumulator.md
STAGE_ACCUMULATOR -- requirements
Module: stage_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each classifier haar value.
REQ-002 SHALL have parameter SUM_WIDTH, default 16: width of the stage sum and the stage threshold.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the feature count.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_start  input  1  begin a stage evaluation; sampled only in IDLE.
REQ-007 i_abort  input  1  discard the current evaluation.
REQ-008 i_num_features  input  CNT_WIDTH  number of feature values in the stage; latched on accepted start.
REQ-009 i_stage_threshold  input  SUM_WIDTH  stage pass threshold, unsigned; latched on accepted start.
REQ-010 i_haarvalue_valid  input  1  i_haarvalue carries one feature result this cycle.
REQ-011 i_haarvalue  input  DATA_WIDTH  unsigned feature result from the upstream classifier.
REQ-012 o_ready  output  1  high in IDLE only.
REQ-013 o_done  output  1  one-cycle pulse: the stage result is valid.
REQ-014 o_pass  output  1  stage verdict; held from o_done until the next accepted start.
REQ-015 o_sum  output  SUM_WIDTH  accumulated stage sum; held with o_pass.
REQ-016 o_feature_count  output  CNT_WIDTH  number of values accepted so far in the current stage.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM, COMPARE and DONE.
REQ-018 IDLE with i_start=1 and i_abort=0: latch the count and threshold, clear the sum and count, clear o_pass; next state ACCUM, or COMPARE if i_num_features=0.
REQ-019 i_start SHALL be ignored outside IDLE; i_haarvalue_valid SHALL be ignored outside ACCUM.
REQ-020 ACCUM, on each cycle with valid=1: sum <= sum + zero-extended i_haarvalue, saturating at 2^SUM_WIDTH-1 (never wraps); count increments by 1.
REQ-021 ACCUM: the valid beat that makes count equal to the latched i_num_features SHALL transition to COMPARE; valid=0 cycles hold the state.
REQ-022 COMPARE (one cycle): o_pass <= (sum >= latched threshold); next state DONE.
REQ-023 DONE (one cycle): o_done=1; next state IDLE.
REQ-024 Latency: last valid beat at edge T -> o_done high during the cycle after edge T+2; an i_start in that following IDLE cycle SHALL be accepted, giving back-to-back stages.
REQ-025 i_abort=1 in any state: next state IDLE; o_done SHALL NOT assert; the sum and count clear; abort wins over a simultaneous start or valid.
REQ-026 o_sum and o_feature_count SHALL be registered and reflect the state after each accepted beat.

Reset
REQ-027 While reset=1 at a clock edge: state IDLE, sum=0, count=0, o_done=0, o_pass=0, latched threshold and count=0; o_ready=1 on the next cycle.
REQ-028 Reset mid-evaluation SHALL discard it with no o_done pulse; reset has priority over i_abort, i_start and valid.

Verification
REQ-029 Run a stage with N=3, threshold=300 and values 100, 120, 90 on consecutive cycles -> o_sum=310, o_pass=1, o_done pulses 2 cycles after the last beat.
REQ-030 Run a stage with N=4, threshold=500, values 100 each, and valid gaps between beats -> o_sum=400, o_pass=0, o_feature_count=4, exactly one o_done.
REQ-031 Run a stage with N=0, threshold=0 -> o_done 2 cycles after start, o_sum=0, o_pass=1; with threshold=1 instead -> o_pass=0.
REQ-032 Run a saturation case with SUM_WIDTH=8, DATA_WIDTH=8, N=3 and values 200, 200, 200 -> o_sum=255, no wrap.
REQ-033 Abort after 2 of 5 beats, then start a new stage with N=1 and value 7 in the same cycle the abort clears -> no o_done for the aborted stage; second stage gives o_sum=7.
REQ-034 Assert reset during ACCUM, then apply i_start while not in IDLE -> outputs at reset values, o_ready=1, the stray start is ignored, no o_done.
